// File: rtl/macc_dot_acc.sv
// macc_dot_acc: signed multiply-accumulate dot-product engine.
// Takes one signed A/B operand pair per cycle, multiplies it in a registered
// pipeline and sums LEN consecutive accepted products into one result that is
// held in an output register until the sink takes it.
//
// Ports:
//   CLK        clock
//   RST        synchronous active-high reset
//   a_in       operand A (signed, WIDTH bits)
//   b_in       operand B (signed, WIDTH bits)
//   in_valid   operand pair valid
//   in_ready   pair can be accepted this cycle (combinational)
//   out_data   dot-product result (signed, ACC_WIDTH bits)
//   out_valid  out_data valid
//   out_ready  sink accepts out_data
//   busy       a partial group or pipeline stage is occupied
module macc_dot_acc #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned LEN       = 4,
    parameter int unsigned ACC_WIDTH = 66
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
);

    localparam int unsigned PROD_W = 2 * WIDTH;
    localparam int unsigned CNT_W  = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(LEN - 1);

    // Handshake and control
    logic                 stall;
    logic                 accept;
    logic                 take_last;
    logic [CNT_W-1:0]     term_cnt;

    // Stage 1: registered operands
    logic                 s1_valid;
    logic                 s1_last;
    logic [WIDTH-1:0]     s1_a;
    logic [WIDTH-1:0]     s1_b;

    // Stage 2: registered full-width product
    logic                 s2_valid;
    logic                 s2_last;
    logic [PROD_W-1:0]    s2_prod;
    logic [PROD_W-1:0]    prod_c;

    // Stage 3: accumulator
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] prod_ext;
    logic [ACC_WIDTH-1:0] sum;
    logic                 complete;

    // A held result that the sink refuses freezes the whole pipeline.
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;
    assign accept    = in_valid & in_ready;
    assign take_last = (term_cnt == LAST_TERM);

    // Term counter: group membership is by accepted-pair count only.
    always_ff @(posedge CLK) begin
        if (RST) begin
            term_cnt <= '0;
        end else if (accept) begin
            if (take_last) begin
                term_cnt <= '0;
            end else begin
                term_cnt <= term_cnt + CNT_W'(1);
            end
        end
    end

    // Stage 1 register: operands plus valid/last tag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (!stall) begin
            s1_valid <= accept;
            s1_last  <= accept & take_last;
            if (accept) begin
                s1_a <= a_in;
                s1_b <= b_in;
            end
        end
    end

    // Exact signed product: both operands sign-extended to the full product width.
    assign prod_c = PROD_W'($signed(s1_a)) * PROD_W'($signed(s1_b));

    // Stage 2 register: product plus valid/last tag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_prod  <= '0;
        end else if (!stall) begin
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            if (s1_valid) begin
                s2_prod <= prod_c;
            end
        end
    end

    // Fit the product to the accumulator width (sign-extend, or wrap when narrower).
    generate
        if (ACC_WIDTH > PROD_W) begin : g_prod_sext
            assign prod_ext = {{(ACC_WIDTH - PROD_W){s2_prod[PROD_W-1]}}, s2_prod};
        end else begin : g_prod_trunc
            assign prod_ext = s2_prod[ACC_WIDTH-1:0];
        end
    endgenerate

    // Modulo-2^ACC_WIDTH running sum.
    assign sum      = acc + prod_ext;
    assign complete = s2_valid & s2_last;

    // Stage 3: accumulate, and on the last term hand the sum to the output register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            acc <= '0;
        end else if (!stall && s2_valid) begin
            if (s2_last) begin
                acc <= '0;
            end else begin
                acc <= sum;
            end
        end
    end

    // Output register: a completion in the same cycle as a consume reloads
    // without a dead cycle; ~stall with out_valid set implies out_ready.
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (!stall) begin
            if (complete) begin
                out_valid <= 1'b1;
                out_data  <= sum;
            end else if (out_valid) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Activity indicator; a waiting result alone does not count.
    assign busy = s1_valid | s2_valid | (term_cnt != '0) | (acc != '0);

endmodule
